multi_edge_detect: RTL and testbench
====================================

# multi_edge_detect

Parametrised, multi-channel successor to the single-bit positive edge detector. Each of WIDTH asynchronous or debounced inputs is synchronised through a configurable flop chain and checked for rising, falling or both edges under a run-time mode. Every detected edge produces a one-cycle pulse, a sticky flag and a saturating event count. The block sits between the debouncers and the counter and display logic, and replaces per-bit edge-detector instances.

## Interface
- WIDTH, 4: number of independent channels (1..32)
- SYNC_STAGES, 2: synchroniser depth per channel (min 2)
- CNT_W, 8: width of each per-channel event counter (1..16)
- clk  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- din  in  WIDTH  channel inputs, asynchronous to clk
- mode  in  2  00 disabled, 01 rising, 10 falling, 11 both edges; applies to all channels
- clr  in  WIDTH  per-channel clear of sticky flag and counter, level, sampled each cycle
- pulse  out  WIDTH  one-cycle registered edge strobe per channel
- sticky  out  WIDTH  per-channel event flag, held until cleared
- count  out  WIDTH*CNT_W  per-channel saturating event counts; channel i at bits [i*CNT_W +: CNT_W]
- any_evt  out  1  OR of pulse

## Operation
- Per channel: sync chain s[0..SYNC_STAGES-1], then history flop h that captures s[last].
- Raw edges: rise = s[last] & ~h; fall = ~s[last] & h.
- The mode selects the qualifying edge (rise, fall, or rise|fall). Mode 00 selects none.
- An arm counter (width to hold SYNC_STAGES+1) counts up from 0 after reset release. Detection is masked until the counter reaches SYNC_STAGES+1, then the counter holds. Inputs already high at reset release therefore never produce a pulse.
- pulse[i] <= armed & qualifying edge[i].
- Sticky update: sticky[i] <= pulse[i] | (sticky[i] & ~clr[i]). Set wins over a simultaneous clear.
- Counter update:
  - If clr[i] is high, count_i <= pulse[i] (0 or 1).
  - Otherwise, count_i <= count_i + pulse[i], saturating at 2^CNT_W-1 with no wrap.
- Mode 00 masks pulse, sticky set and counting. The sync chain and h keep tracking din, so re-enabling a mode never generates a spurious edge from stale history.
- A mode change affects edges qualified in the same cycle the new mode is sampled. There is no pipelining of mode.
- any_evt is the combinational OR of the registered pulse vector (glitch-free).

## Timing
- Reset asserted (low), asynchronously:
  - all sync flops, h, pulse, sticky, count and arm counter go to 0
  - any_evt = 0
- Latency: din[i] changes and is stable at clk edge k. The qualifying pulse[i] is high from edge k+SYNC_STAGES to k+SYNC_STAGES+1, exactly one cycle. sticky and count update at edge k+SYNC_STAGES+1.
- Input held stable: one pulse only. Toggles on consecutive cycles: one pulse per qualifying transition. Back-to-back pulses are allowed with no dead cycle.
- Arm window: the first SYNC_STAGES+1 edges after reset deassert yield no pulse, regardless of din.
- Reset mid-operation: all state clears immediately, and the arm window restarts on release.
- Saturation: count stays at max. sticky still sets, and pulse still fires.
- Channels are fully independent. Simultaneous edges on all channels give a pulse on all channels in the same cycle.

## Test plan
- Reset then arm:
  - Stimulus: WIDTH=4, SYNC_STAGES=2, mode=01. Hold din=4'b1111 through reset release.
  - Response: pulse=0 for all cycles; count=0; sticky=0.
- Rising latency:
  - Stimulus: mode=01. Change din[0] 0->1, sampled at edge k.
  - Response: pulse[0]=1 only in the cycle after edge k+2; sticky[0]=1 and count0=1 from edge k+3; any_evt mirrors pulse.
- Both-edge mode:
  - Stimulus: mode=11. Toggle din[2] 0->1->0 with 5-cycle spacing.
  - Response: two single-cycle pulses on channel 2; count2=2. Repeat with mode=10: one pulse on the falling edge only.
- Clear collision:
  - Stimulus: assert clr[1] in the same cycle that pulse[1] is high.
  - Response: sticky[1] stays 1; count1=1.
  - Stimulus: clr[1] alone.
  - Response: sticky[1]=0; count1=0.
- Saturation:
  - Stimulus: CNT_W=3. Apply 10 rising edges on din[3].
  - Response: count3=7 and holds; 10 pulses still observed.
- Disable and re-enable plus mid-run reset:
  - Stimulus: mode=00. Raise din[0], then set mode=01 with no further din[0] change.
  - Response: no pulse.
  - Stimulus: assert reset mid-count.
  - Response: all outputs 0 at once; arm window of 3 cycles re-observed after release.

Source files
------------

// File: rtl/multi_edge_detect.sv
// rtl/multi_edge_detect.sv - multi-channel synchronised edge detector with sticky flags and saturating counts
module multi_edge_detect #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       din,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       clr,
    output logic [WIDTH-1:0]       pulse,
    output logic [WIDTH-1:0]       sticky,
    output logic [WIDTH*CNT_W-1:0] count,
    output logic                   any_evt
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  hist_q;
    logic [WIDTH-1:0]                  pulse_q, pulse_d;
    logic [WIDTH-1:0]                  sticky_q, sticky_d;
    logic [WIDTH-1:0][CNT_W-1:0]       count_q, count_d;
    logic [ARM_W-1:0]                  arm_q, arm_d;

    logic             armed;
    logic [WIDTH-1:0] rise, fall, qual;

    // Detection stays masked until the synchroniser and history flops hold post-reset data.
    always_comb begin
        armed = (arm_q == ARM_DONE);
        arm_d = armed ? arm_q : arm_q + 1'b1;
    end

    always_comb begin
        rise = sync_q[SYNC_STAGES-1] & ~hist_q;
        fall = ~sync_q[SYNC_STAGES-1] & hist_q;
        case (mode)
            2'b01:   qual = rise;
            2'b10:   qual = fall;
            2'b11:   qual = rise | fall;
            default: qual = '0;
        endcase
        pulse_d  = armed ? qual : '0;
        sticky_d = pulse_q | (sticky_q & ~clr);
    end

    always_comb begin
        count_d = count_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (clr[i]) begin
                count_d[i] = CNT_W'(pulse_q[i]);
            end else if (pulse_q[i] && (count_q[i] != CNT_MAX)) begin
                count_d[i] = count_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            hist_q   <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
            count_q  <= '0;
            arm_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q   <= sync_q[SYNC_STAGES-1];
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            arm_q    <= arm_d;
        end
    end

    assign pulse   = pulse_q;
    assign sticky  = sticky_q;
    assign count   = count_q;
    assign any_evt = |pulse_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// tb/tb_multi_edge_detect.sv - randomized and directed bench for multi_edge_detect against an edge-history model
module tb_multi_edge_detect;

    localparam int W    = 4;
    localparam int S    = 2;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    din, clr, pulse, sticky;
    logic [1:0]      mode;
    logic [W*CW-1:0] count;
    logic            any_evt;

    multi_edge_detect #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr),
        .pulse(pulse), .sticky(sticky), .count(count), .any_evt(any_evt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // samp[j] holds din as sampled j edges ago; pre-release history reads as zero.
    logic [W-1:0] samp[$];
    int           edge_n;
    logic [W-1:0] m_pulse, m_sticky;
    int           m_cnt[W];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        for (int j = 0; j < S + 2; j++) samp.push_back('0);
        edge_n   = 0;
        m_pulse  = '0;
        m_sticky = '0;
        for (int i = 0; i < W; i++) m_cnt[i] = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, " pulse"},  32'(pulse),   32'(m_pulse));
        check_eq({tag, " sticky"}, 32'(sticky),  32'(m_sticky));
        check_eq({tag, " any"},    32'(any_evt), 32'(|m_pulse));
        for (int i = 0; i < W; i++)
            check_eq($sformatf("%s cnt%0d", tag, i), 32'(count[i*CW +: CW]), 32'(m_cnt[i]));
    endtask

    // Entered and left at a falling edge; inputs are sampled by the next rising edge.
    task automatic step(input logic [W-1:0] d, input logic [1:0] m, input logic [W-1:0] c, input string tag);
        logic [W-1:0] cur, prev, qual, old_p;
        din  = d;
        mode = m;
        clr  = c;
        @(posedge clk);
        edge_n++;
        samp.push_front(d);
        cur  = samp[S];
        prev = samp[S+1];
        void'(samp.pop_back());
        qual = '0;
        if (m[0]) qual |= cur & ~prev;
        if (m[1]) qual |= ~cur & prev;
        old_p   = m_pulse;
        m_pulse = (edge_n >= S + 2) ? qual : '0;
        for (int i = 0; i < W; i++) begin
            if (c[i])                          m_cnt[i] = int'(old_p[i]);
            else if (old_p[i] && m_cnt[i] < MAXC) m_cnt[i]++;
        end
        m_sticky = old_p | (m_sticky & ~c);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " pulse"},  32'(pulse),   32'h0);
        check_eq({tag, " sticky"}, 32'(sticky),  32'h0);
        check_eq({tag, " count"},  32'(count),   32'h0);
        check_eq({tag, " any"},    32'(any_evt), 32'h0);
    endtask

    int pulses3;

    initial begin
        reset = 1'b0;
        din   = 4'hF;
        mode  = 2'b01;
        clr   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset = 1'b1;

        // Inputs high through release must never pulse.
        repeat (6) step(4'hF, 2'b01, 4'h0, "arm");

        repeat (4) step(4'hE, 2'b01, 4'h0, "lat_pre");
        repeat (5) step(4'hF, 2'b01, 4'h0, "lat");

        repeat (5) step(4'hB, 2'b01, 4'h0, "both_pre");
        repeat (5) step(4'hF, 2'b11, 4'h0, "both_r");
        repeat (5) step(4'hB, 2'b11, 4'h0, "both_f");
        repeat (5) step(4'hF, 2'b10, 4'h0, "fall_r");
        repeat (5) step(4'hB, 2'b10, 4'h0, "fall_f");

        repeat (4) step(4'h9, 2'b01, 4'h0, "clr_pre");
        step(4'hB, 2'b01, 4'h0, "clr_edge");
        step(4'hB, 2'b01, 4'h0, "clr_wait");
        step(4'hB, 2'b01, 4'h0, "clr_pulse");
        step(4'hB, 2'b01, 4'h2, "clr_coll");
        repeat (2) step(4'hB, 2'b01, 4'h0, "clr_hold");
        step(4'hB, 2'b01, 4'h2, "clr_alone");
        repeat (2) step(4'hB, 2'b01, 4'h0, "clr_after");

        pulses3 = 0;
        for (int k = 0; k < 10; k++) begin
            step(4'h3, 2'b01, 4'h0, "sat_lo");
            pulses3 += int'(pulse[3]);
            step(4'hB, 2'b01, 4'h0, "sat_hi");
            pulses3 += int'(pulse[3]);
        end
        repeat (3) begin
            step(4'hB, 2'b01, 4'h0, "sat_tail");
            pulses3 += int'(pulse[3]);
        end
        check_eq("sat pulses", 32'(pulses3), 32'd10);
        check_eq("sat count3", 32'(count[3*CW +: CW]), 32'(MAXC));

        repeat (4) step(4'hA, 2'b01, 4'h0, "dis_pre");
        repeat (4) step(4'hB, 2'b00, 4'h0, "dis_raise");
        repeat (4) step(4'hB, 2'b01, 4'h0, "dis_reen");

        #2 reset = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        check_zero("midrst_hold");
        din = 4'hF;
        reset = 1'b1;
        model_reset();
        step(4'hF, 2'b11, 4'h0, "rearm");
        step(4'h5, 2'b11, 4'h0, "rearm");
        repeat (5) step(4'h5, 2'b11, 4'h0, "rearm");

        for (int k = 0; k < 600; k++) begin
            logic [W-1:0] d, c;
            logic [1:0]   m;
            d = din ^ W'($urandom_range(0, 3) == 0 ? $urandom : 0);
            m = ($urandom_range(0, 15) == 0) ? 2'($urandom) : mode;
            c = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            step(d, m, c, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
